neuron_bwd: RTL and testbench

Backward-pass companion to the combinational forward neuron. It accepts one scalar output error (delta) together with the forward input vector that produced it. It then serially computes the input-error vector grad_in[i] = w[i]*delta and the weight-gradient vector grad_w[i] = x[i]*delta, both requantised to WIDTH bits. It sits between the loss/next-layer error source and the weight-update logic, and uses valid/ready handshakes on both sides.

---
 rtl/neuron_pkg.sv | 30 +++
 rtl/fx_requant.sv | 29 ++
 rtl/neuron_bwd.sv | 130 +++++++++++++
 tb/tb_neuron_bwd.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and the fixed-point requantiser for the neuron datapaths.
// Defaults match the forward neuron so both directions agree on format.
package neuron_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Returns {sat, value}: floor-shift by frac, then clamp to the WIDTH_DEF range.
  function automatic logic [WIDTH_DEF:0] requant(input logic signed [2*WIDTH_DEF-1:0] prod,
                                                  input int unsigned frac);
    logic signed [2*WIDTH_DEF-1:0] sh;
    logic                          in_range;
    sh       = prod >>> frac;
    in_range = (&sh[2*WIDTH_DEF-1:WIDTH_DEF-1]) || !(|sh[2*WIDTH_DEF-1:WIDTH_DEF-1]);
    if (in_range) begin
      return {1'b0, sh[WIDTH_DEF-1:0]};
    end else if (sh[2*WIDTH_DEF-1]) begin
      return {1'b1, 1'b1, {(WIDTH_DEF-1){1'b0}}};
    end else begin
      return {1'b1, 1'b0, {(WIDTH_DEF-1){1'b1}}};
    end
  endfunction

endpackage

// File: rtl/fx_requant.sv
// Combinational requantiser: 2*WIDTH signed product -> WIDTH bits.
// Floor shift by FRAC (arithmetic), then saturate and flag it.
module fx_requant
  import neuron_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [2*WIDTH-1:0] prod_i,
  output logic signed [WIDTH-1:0]   q_o,
  output logic                      sat_o
);

  logic signed [2*WIDTH-1:0] shifted;
  logic                      in_range;

  assign shifted = prod_i >>> FRAC;
  // Representable only when the discarded top bits are all copies of the new sign bit.
  assign in_range = (&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]);
  assign sat_o    = !in_range;

  always_comb begin
    q_o = shifted[WIDTH-1:0];
    if (!in_range) begin
      q_o = shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/neuron_bwd.sv
// Serial backward pass: grad_in[i] = w[i]*delta, grad_w[i] = x[i]*delta, one element per cycle.
// Accept -> results valid after N CALC cycles; results held in DONE until out_ready.
module neuron_bwd
  import neuron_pkg::*;
#(
  parameter int                 WIDTH        = WIDTH_DEF,
  parameter int                 N            = 4,
  parameter int                 FRAC         = FRAC_DEF,
  parameter logic [N*WIDTH-1:0] WEIGHTS_FLAT = {16'd3072, 16'd7808, -16'd2560, -16'd77}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] delta,
  input  logic signed [WIDTH-1:0] x_in    [N],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] grad_in [N],
  output logic signed [WIDTH-1:0] grad_w  [N],
  output logic                    sat
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  state_t                  state_q;
  logic [IDXW-1:0]         idx_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    sat_q;
  logic signed [WIDTH-1:0] delta_q;
  logic signed [WIDTH-1:0] x_q       [N];
  logic signed [WIDTH-1:0] grad_in_q [N];
  logic signed [WIDTH-1:0] grad_w_q  [N];

  logic signed [WIDTH-1:0]   w_sel;
  logic signed [WIDTH-1:0]   x_sel;
  logic signed [2*WIDTH-1:0] p_in;
  logic signed [2*WIDTH-1:0] p_w;
  logic signed [WIDTH-1:0]   q_in;
  logic signed [WIDTH-1:0]   q_w;
  logic                      s_in;
  logic                      s_w;

  // Weight 0 lives in the most significant chunk of WEIGHTS_FLAT.
  always_comb begin
    w_sel = '0;
    x_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        w_sel = $signed(WEIGHTS_FLAT[(N-i)*WIDTH-1 -: WIDTH]);
        x_sel = x_q[i];
      end
    end
  end

  assign p_in = (2*WIDTH)'(w_sel) * (2*WIDTH)'(delta_q);
  assign p_w  = (2*WIDTH)'(x_sel) * (2*WIDTH)'(delta_q);

  fx_requant #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rq_in (
    .prod_i (p_in),
    .q_o    (q_in),
    .sat_o  (s_in)
  );

  fx_requant #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rq_w (
    .prod_i (p_w),
    .q_o    (q_w),
    .sat_o  (s_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      delta_q     <= '0;
      for (int i = 0; i < N; i++) begin
        x_q[i]       <= '0;
        grad_in_q[i] <= '0;
        grad_w_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            delta_q    <= delta;
            x_q        <= x_in;
            sat_q      <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          grad_in_q[idx_q] <= q_in;
          grad_w_q[idx_q]  <= q_w;
          sat_q            <= sat_q | s_in | s_w;
          if (idx_q == IDXW'(N-1)) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;
  assign grad_in   = grad_in_q;
  assign grad_w    = grad_w_q;

endmodule

// File: tb/tb_neuron_bwd.sv
// Directed bench for neuron_bwd: hand-computed vectors plus a small reference model for back-to-back traffic.
module tb_neuron_bwd;

  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int FRAC  = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] delta;
  logic signed [WIDTH-1:0] x_in    [N];
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] grad_in [N];
  logic signed [WIDTH-1:0] grad_w  [N];
  logic                    sat;

  int n_checks = 0;
  int n_fail   = 0;

  int W [N] = '{3072, 7808, -2560, -77};

  always #5 clk = ~clk;

  neuron_bwd #(
    .WIDTH        (WIDTH),
    .N            (N),
    .FRAC         (FRAC),
    .WEIGHTS_FLAT ({16'd3072, 16'd7808, -16'd2560, -16'd77})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .delta     (delta),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_in   (grad_in),
    .grad_w    (grad_w),
    .sat       (sat)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_txn(input int d, input int a, input int b, input int c, input int e);
    delta   = WIDTH'(d);
    x_in[0] = WIDTH'(a);
    x_in[1] = WIDTH'(b);
    x_in[2] = WIDTH'(c);
    x_in[3] = WIDTH'(e);
  endtask

  task automatic send(input int d, input int a, input int b, input int c, input int e);
    int k;
    set_txn(d, a, b, c, e);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    chk("accept in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  // lat = edge (counted from the accept edge) at which out_valid is first sampled high
  task automatic wait_out(output int lat);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      step();
      k++;
    end
    chk("out_valid arrives", out_valid, 1);
    lat = k + 1;
  endtask

  task automatic check_vec(input string tag, input int ei [N], input int ew [N], input int es);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s grad_in[%0d]", tag, i), grad_in[i], ei[i]);
      chk($sformatf("%s grad_w[%0d]", tag, i), grad_w[i], ew[i]);
    end
    chk({tag, " sat"}, sat, es);
  endtask

  // Reference requantiser: {sat, value}
  function automatic logic [WIDTH:0] rq(input longint p);
    longint q;
    q = p >>> FRAC;
    if (q > 32767)       return {1'b1, 16'h7fff};
    else if (q < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, q[15:0]};
  endfunction

  initial begin
    int lat;
    int dl [3];
    int xl [3][N];
    int acc_t [3];
    int n_acc, n_out, cyc, extra;
    logic acc, got;
    logic [WIDTH:0] r;
    int ei [N];
    int ew [N];
    int es;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_txn(0, 0, 0, 0, 0);

    // Reset state
    step();
    step();
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    check_vec("reset", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    rst = 1'b0;
    step();

    // Unity delta: outputs reproduce the weights and inputs
    send(256, -384, 358, -77, 2586);
    wait_out(lat);
    chk("unity latency", lat, N + 1);
    check_vec("unity", '{3072, 7808, -2560, -77}, '{-384, 358, -77, 2586}, 0);
    step();
    chk("unity out_valid drops", out_valid, 0);
    chk("unity in_ready back", in_ready, 1);

    // Scale x2, then hold it under backpressure while new data waits
    out_ready = 1'b0;
    send(512, -384, 358, -77, 2586);
    wait_out(lat);
    check_vec("scale2", '{6144, 15616, -5120, -154}, '{-768, 716, -154, 5172}, 0);
    set_txn(32767, 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp out_valid", out_valid, 1);
      chk("bp in_ready", in_ready, 0);
      check_vec("bp hold", '{6144, 15616, -5120, -154}, '{-768, 716, -154, 5172}, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("bp accepted", in_ready, 0);
    wait_out(lat);
    check_vec("saturate", '{32767, 32767, -32768, -9856}, '{0, 0, 0, 0}, 1);
    step();

    // Reset in the middle of CALC (index 2 being processed)
    send(512, 100, 200, 300, 400);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    check_vec("midrst", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    send(256, -384, 358, -77, 2586);
    wait_out(lat);
    check_vec("post-reset unity", '{3072, 7808, -2560, -77}, '{-384, 358, -77, 2586}, 0);
    step();

    // Back-to-back with in_valid and out_ready held high
    dl = '{-300, 100, -32768};
    xl = '{'{1000, -2000, 123, -32768}, '{5, -5, 32767, -1}, '{-32768, 1, -1, 256}};
    n_acc = 0;
    n_out = 0;
    cyc   = 0;
    set_txn(dl[0], xl[0][0], xl[0][1], xl[0][2], xl[0][3]);
    in_valid = 1'b1;
    while (n_out < 3 && cyc < 60) begin
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      if (got) begin
        es = 0;
        for (int i = 0; i < N; i++) begin
          r = rq(longint'(W[i]) * longint'(dl[n_out]));
          ei[i] = int'($signed(r[WIDTH-1:0]));
          es = es | int'(r[WIDTH]);
          r = rq(longint'(xl[n_out][i]) * longint'(dl[n_out]));
          ew[i] = int'($signed(r[WIDTH-1:0]));
          es = es | int'(r[WIDTH]);
        end
        check_vec($sformatf("b2b txn%0d", n_out), ei, ew, es);
        n_out++;
      end
      step();
      cyc++;
      if (acc) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc < 3) set_txn(dl[n_acc], xl[n_acc][0], xl[n_acc][1], xl[n_acc][2], xl[n_acc][3]);
        else in_valid = 1'b0;
      end
    end
    chk("b2b outputs", n_out, 3);
    chk("b2b accepts", n_acc, 3);
    chk("b2b spacing 0-1", acc_t[1] - acc_t[0], N + 2);
    chk("b2b spacing 1-2", acc_t[2] - acc_t[1], N + 2);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) extra++;
      step();
    end
    chk("b2b no duplicate output", extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
